// File: rtl/float_div_pkg.sv
// Shared definitions for the float32 divider back end.
//   - special_t : operand class carried in the reciprocal word
//   - X_*       : bit offsets of the fields in the 37-bit reciprocal word
//   - state_t   : quotient FSM states
//   - QNAN/BIAS : canonical quiet NaN and binary32 exponent bias
package float_div_pkg;

  typedef enum logic [1:0] {
    SP_NORM = 2'b00,
    SP_ZERO = 2'b01,
    SP_INF  = 2'b10,
    SP_NAN  = 2'b11
  } special_t;

  // x = {sign[36], special[35:34], exp[33:24], man[23:0]}
  localparam int X_SIGN_BIT = 36;
  localparam int X_SP_LSB   = 34;
  localparam int X_EXP_LSB  = 24;
  localparam int X_EXP_W    = 10;
  localparam int X_MAN_LSB  = 0;
  localparam int X_HALF_W   = 12;  // multiplier slice of the 24-bit significand

  typedef enum logic [2:0] {
    IDLE,
    MUL_LO,
    MUL_HI,
    NORM,
    DONE
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam int          BIAS = 127;

endpackage

// File: rtl/float_div_quot_round.sv
// Combinational normalise / round-to-nearest-even / range check / special
// select / pack for the divider quotient.
// Ports:
//   p      in  48  raw significand product (1.23 x 1.23 -> 2.46)
//   e      in  11  signed unbiased exponent before normalisation
//   sign   in   1  result sign
//   b_zero, b_inf, b_nan  in  dividend class flags
//   x_sp   in   2  reciprocal class (special_t)
//   q      out 32  packed binary32 result
module float_div_quot_round
  import float_div_pkg::*;
(
  input  logic [47:0] p,
  input  logic [10:0] e,
  input  logic        sign,
  input  logic        b_zero,
  input  logic        b_inf,
  input  logic        b_nan,
  input  special_t    x_sp,
  output logic [31:0] q
);

  logic [22:0] man_t;
  logic        guard;
  logic        sticky;
  logic [23:0] man_r;
  logic [12:0] exp_b;

  always_comb begin
    // Product lies in [1,4): a set top bit means one extra exponent step.
    if (p[47]) begin
      man_t  = p[46:24];
      guard  = p[23];
      sticky = |p[22:0];
    end else begin
      man_t  = p[45:23];
      guard  = p[22];
      sticky = |p[21:0];
    end

    // RNE: increment on guard unless an exact tie with an even LSB.
    // A carry out leaves man_r[22:0] all zero, which is the wanted mantissa.
    man_r = {1'b0, man_t} + 24'(guard & (sticky | man_t[0]));

    // 13 bits holds the biased exponent for every reachable input range.
    exp_b = {{2{e[10]}}, e} + 13'(p[47]) + 13'(man_r[23]) + 13'(BIAS);

    if (b_nan || x_sp == SP_NAN) begin
      q = QNAN;
    end else if (b_zero && x_sp == SP_INF) begin
      q = QNAN;
    end else if (b_inf && x_sp == SP_ZERO) begin
      q = QNAN;
    end else if (b_inf || x_sp == SP_INF) begin
      q = {sign, 8'hFF, 23'd0};
    end else if (b_zero || x_sp == SP_ZERO) begin
      q = {sign, 31'd0};
    end else if ($signed(exp_b) >= 13'sd255) begin
      q = {sign, 8'hFF, 23'd0};
    end else if ($signed(exp_b) <= 13'sd0) begin
      q = {sign, 31'd0};  // no denormal outputs
    end else begin
      q = {sign, exp_b[7:0], man_r[22:0]};
    end
  end

endmodule

// File: rtl/float_div_cynw_cm_quot_e8_m23.sv
// Float32 divider back end: q = b * (1/a) from the dividend and the
// reciprocal word x. A 24x12 multiplier is shared over MUL_LO / MUL_HI to
// build the 48-bit product, then NORM rounds and packs into the q register.
// Ports:
//   aclk, areset (sync, active-high), astall (freezes all state)
//   in_valid/in_ready   operand handshake (b_sign, b_exp, b_man, x)
//   out_valid/out_ready quotient handshake (q, registered)
module float_div_cynw_cm_quot_e8_m23
  import float_div_pkg::*;
#(
  parameter int MAN_W = 23,
  parameter int EXP_W = 8,
  parameter int X_W   = 37
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             astall,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             b_sign,
  input  logic [EXP_W-1:0] b_exp,
  input  logic [MAN_W-1:0] b_man,
  input  logic [X_W-1:0]   x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      q
);

  state_t           state_q, state_d;
  logic             b_sign_q, b_sign_d;
  logic [EXP_W-1:0] b_exp_q, b_exp_d;
  logic [MAN_W-1:0] b_man_q, b_man_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [47:0]      acc_q, acc_d;
  logic [31:0]      q_q, q_d;
  logic             out_valid_q, out_valid_d;

  logic [MAN_W:0]    mb;
  logic [X_HALF_W-1:0] mul_sel;
  logic [35:0]       prod;
  logic [10:0]       e_w;
  logic [31:0]       q_round;
  logic              b_zero, b_inf, b_nan;

  // Denormal dividends get no hidden bit and are classed as zero below.
  assign mb      = {b_exp_q != '0, b_man_q};
  assign mul_sel = (state_q == MUL_LO) ? x_q[X_MAN_LSB +: X_HALF_W]
                                       : x_q[X_MAN_LSB + X_HALF_W +: X_HALF_W];
  assign prod    = 36'(mb) * 36'(mul_sel);

  // 11-bit two's-complement sum; x.exp is sign-extended from 10 bits.
  assign e_w = 11'(b_exp_q) - 11'(BIAS)
             + {x_q[X_EXP_LSB + X_EXP_W - 1], x_q[X_EXP_LSB +: X_EXP_W]};

  assign b_zero = (b_exp_q == '0);
  assign b_inf  = (b_exp_q == '1) && (b_man_q == '0);
  assign b_nan  = (b_exp_q == '1) && (b_man_q != '0);

  float_div_quot_round u_round (
    .p      (acc_q),
    .e      (e_w),
    .sign   (b_sign_q ^ x_q[X_SIGN_BIT]),
    .b_zero (b_zero),
    .b_inf  (b_inf),
    .b_nan  (b_nan),
    .x_sp   (special_t'(x_q[X_SP_LSB +: 2])),
    .q      (q_round)
  );

  always_comb begin
    state_d     = state_q;
    b_sign_d    = b_sign_q;
    b_exp_d     = b_exp_q;
    b_man_d     = b_man_q;
    x_d         = x_q;
    acc_d       = acc_q;
    q_d         = q_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          b_sign_d = b_sign;
          b_exp_d  = b_exp;
          b_man_d  = b_man;
          x_d      = x;
          state_d  = MUL_LO;
        end
      end
      MUL_LO: begin
        acc_d   = {12'd0, prod};
        state_d = MUL_HI;
      end
      MUL_HI: begin
        acc_d   = acc_q + {prod, 12'd0};
        state_d = NORM;
      end
      NORM: begin
        q_d         = q_round;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stall freezes everything, so handshakes in a stalled cycle are ignored.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= IDLE;
      b_sign_q    <= 1'b0;
      b_exp_q     <= '0;
      b_man_q     <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      q_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (!astall) begin
      state_q     <= state_d;
      b_sign_q    <= b_sign_d;
      b_exp_q     <= b_exp_d;
      b_man_q     <= b_man_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      q_q         <= q_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Combinational so a stalled cycle can never look like an acceptance.
  assign in_ready  = (state_q == IDLE) && !astall;
  assign out_valid = out_valid_q;
  assign q         = q_q;

endmodule

// File: tb/tb_float_div_cynw_cm_quot_e8_m23.sv
module tb_float_div_cynw_cm_quot_e8_m23;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        astall = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        b_sign = 1'b0;
  logic [7:0]  b_exp = 8'd0;
  logic [22:0] b_man = 23'd0;
  logic [36:0] x = 37'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] q;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  logic [31:0] sb[$];

  localparam logic [36:0] X_HALF  = {1'b0, 2'b00, 10'h3FF, 24'h800000};
  localparam logic [36:0] X_THIRD = {1'b0, 2'b00, 10'h3FE, 24'hAAAAAB};
  localparam logic [36:0] X_1P5   = {1'b0, 2'b00, 10'h000, 24'hC00000};
  localparam logic [36:0] X_TWO   = {1'b0, 2'b00, 10'h001, 24'h800000};
  localparam logic [36:0] X_INF   = {1'b0, 2'b10, 10'h000, 24'h000000};
  localparam logic [36:0] X_ZERO  = {1'b0, 2'b01, 10'h000, 24'h000000};
  localparam logic [36:0] X_NAN   = {1'b0, 2'b11, 10'h000, 24'h000000};

  float_div_cynw_cm_quot_e8_m23 dut (
    .aclk      (aclk),
    .areset    (areset),
    .astall    (astall),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .b_sign    (b_sign),
    .b_exp     (b_exp),
    .b_man     (b_man),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one operand pair, wait (bounded) for acceptance, optionally
  // record the expected quotient. Returns on the negedge after the accept edge.
  task automatic send(input string tag, input logic [31:0] b, input logic [36:0] xw,
                      input logic [31:0] expq, input bit track);
    int n = 0;
    @(negedge aclk);
    {b_sign, b_exp, b_man} = b;
    x = xw;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge aclk);
      n++;
    end
    check({tag, " accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge aclk);
    if (track) sb.push_back(expq);
    @(negedge aclk);
    in_valid = 1'b0;
    acc_cyc = cyc;
    check({tag, " in_ready_busy"}, {31'd0, in_ready}, 32'd0);
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard, optionally
  // hold out_ready low for some cycles, then complete the handshake.
  // Latency counts clock edges from the accept edge to the first edge that
  // samples out_valid high.
  task automatic receive(input string tag, input int hold, input int exp_lat);
    int k = 0;
    logic [31:0] expq;
    while (!out_valid && k < 50) begin
      @(negedge aclk);
      k++;
    end
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " latency"}, 32'(cyc - acc_cyc + 1), 32'(exp_lat));
    expq = (sb.size() > 0) ? sb.pop_front() : 32'hDEADBEEF;
    check({tag, " q"}, q, expq);
    for (int i = 0; i < hold; i++) begin
      @(negedge aclk);
      check({tag, " q_hold"}, q, expq);
      check({tag, " valid_hold"}, {31'd0, out_valid}, 32'd1);
      check({tag, " in_ready_hold"}, {31'd0, in_ready}, 32'd0);
    end
    $display("op %s q=%h expected=%h latency=%0d", tag, q, expq, cyc - acc_cyc + 1);
    out_ready = 1'b1;
    @(posedge aclk);
    @(negedge aclk);
    out_ready = 1'b0;
    check({tag, " valid_drop"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst q", q, 32'd0);
    check("rst in_ready", {31'd0, in_ready}, 32'd1);

    // Stall forces in_ready low even in IDLE
    astall = 1'b1;
    #1 check("stall in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge aclk);
    astall = 1'b0;

    // Main function
    send("6/2", 32'h40C00000, X_HALF, 32'h40400000, 1'b1);
    receive("6/2", 0, 4);
    send("1/3", 32'h3F800000, X_THIRD, 32'h3EAAAAAB, 1'b1);
    receive("1/3", 0, 4);
    send("tie_odd", 32'h3F800001, X_1P5, 32'h3FC00002, 1'b1);
    receive("tie_odd", 0, 4);
    send("tie_even", 32'h3F800003, X_1P5, 32'h3FC00004, 1'b1);
    receive("tie_even", 0, 4);
    send("overflow", 32'h7F000000, X_TWO, 32'h7F800000, 1'b1);
    receive("overflow", 0, 4);
    send("underflow", 32'h00800000, X_HALF, 32'h00000000, 1'b1);
    receive("underflow", 0, 4);

    // Specials
    send("0/0", 32'h00000000, X_INF, 32'h7FC00000, 1'b1);
    receive("0/0", 0, 4);
    send("-inf", 32'hFF800000, X_HALF, 32'hFF800000, 1'b1);
    receive("-inf", 0, 4);
    send("b/inf", 32'h40000000, X_ZERO, 32'h00000000, 1'b1);
    receive("b/inf", 0, 4);
    send("x_nan", 32'h40C00000, X_NAN, 32'h7FC00000, 1'b1);
    receive("x_nan", 0, 4);
    send("b_nan", 32'h7FC00001, X_HALF, 32'h7FC00000, 1'b1);
    receive("b_nan", 0, 4);

    // Backpressure: out_ready low for 3 cycles
    send("bp", 32'h40C00000, X_HALF, 32'h40400000, 1'b1);
    receive("bp", 3, 4);

    // Stall for 2 cycles while in MUL_HI
    send("stall_hi", 32'h3F800000, X_THIRD, 32'h3EAAAAAB, 1'b1);
    @(negedge aclk);
    astall = 1'b1;
    repeat (2) @(negedge aclk);
    astall = 1'b0;
    receive("stall_hi", 0, 6);

    // out_ready during a stalled cycle is ignored
    send("stall_done", 32'h40C00000, X_HALF, 32'h40400000, 1'b1);
    repeat (3) @(negedge aclk);
    astall = 1'b1;
    out_ready = 1'b1;
    @(negedge aclk);
    out_ready = 1'b0;
    astall = 1'b0;
    check("stall_done valid_kept", {31'd0, out_valid}, 32'd1);
    receive("stall_done", 0, 5);

    // Reset while in MUL_LO discards the operation
    send("rst_mid", 32'h40C00000, X_HALF, 32'h0, 1'b0);
    areset = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    check("rst_mid out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid in_ready", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (out_valid) seen++;
    end
    check("rst_mid no_output", 32'(seen), 32'd0);
    send("after_rst", 32'h40C00000, X_HALF, 32'h40400000, 1'b1);
    receive("after_rst", 0, 4);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
